// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues one outstanding imem request at a time
// and buffers returned words with their PCs in a 2-entry FIFO for decode.
module fetch_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ILEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_in,
    output logic             pc_advance,
    input  logic             flush,
    output logic             imem_req_valid,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_req_ready,
    input  logic             imem_rsp_valid,
    input  logic [ILEN-1:0]  imem_rsp_data,
    output logic             id_valid,
    output logic [ILEN-1:0]  id_instr,
    output logic [WIDTH-1:0] id_pc,
    input  logic             id_ready
);

    localparam int unsigned CNT_W = 2;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    typedef struct packed {
        logic [ILEN-1:0]  instr;
        logic [WIDTH-1:0] pc;
    } fetch_entry_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pc_q;
    logic [CNT_W-1:0]   count_q;
    logic               rd_ptr_q, wr_ptr_q;
    fetch_entry_t       buf_q [2];
    logic               push, push_ok, pop;

    assign imem_req_addr = {pc_in[WIDTH-1:2], 2'b00};

    // Next-state and request/handshake decode
    always_comb begin
        state_d        = state_q;
        imem_req_valid = 1'b0;
        pc_advance     = 1'b0;
        push           = 1'b0;
        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if ((count_q < FULL) && !flush) begin
                    imem_req_valid = 1'b1;
                    if (imem_req_ready) begin
                        pc_advance = 1'b1;
                        state_d    = WAIT;
                    end
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    push    = !flush;
                    state_d = REQ;
                end else if (flush) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_rsp_valid) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            if (pc_advance) pc_q <= pc_in;
        end
    end

    assign id_valid = (count_q != '0);
    assign pop      = id_valid && id_ready && !flush;
    // A push into a full buffer is only legal when the head leaves the same cycle
    assign push_ok  = push && ((count_q != FULL) || pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q  <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else if (flush) begin
            count_q  <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            if (push_ok) begin
                buf_q[wr_ptr_q] <= '{instr: imem_rsp_data, pc: pc_q};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            unique case ({push_ok, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign id_instr = id_valid ? buf_q[rd_ptr_q].instr : '0;
    assign id_pc    = id_valid ? buf_q[rd_ptr_q].pc    : '0;

endmodule
